button_event_decoder: RTL and testbench

Converts the single debounced button level produced by the debouncer stage into one-cycle gesture events: press, release, single click, double click, long press and auto-repeat. It sits directly downstream of the debouncer, so its input is already clean and synchronous to the clock. Its pulses feed the control and UI logic, which never has to time button levels itself.

---
 rtl/button_event_decoder.sv | 215 +++++++++++++++++++++
 tb/tb_button_event_decoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// ---------------------------------------------------------------------------
// button_event_decoder
//
// Turns the clean, clock-synchronous button level from the debouncer into
// one-cycle gesture pulses. Downstream control/UI logic only has to watch for
// these pulses and never has to time button levels itself.
//
// Parameters:
//   p_counter_width  width of the shared cycle counter; every timing
//                    parameter below must fit in it
//   p_long_cycles    consecutive high samples that make a press "long" (>= 2)
//   p_repeat_cycles  auto-repeat period while a long press is held (>= 1)
//   p_double_cycles  window after a short release in which a second press
//                    counts as a double click (>= 1)
//
// Ports:
//   i_w_clk      clock, everything on the rising edge
//   i_w_reset    asynchronous, active-low reset
//   i_w_level    debounced button level, 1 = pressed
//   o_w_press    one-cycle pulse on every accepted press
//   o_w_release  one-cycle pulse on every release
//   o_w_single   one-cycle pulse when a short click is confirmed as single
//   o_w_double   one-cycle pulse on the second press of a double click
//   o_w_long     one-cycle pulse when the long-press threshold is reached
//   o_w_repeat   one-cycle pulse every p_repeat_cycles while long-held
//   o_w_held     level, high while the button is considered held
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module button_event_decoder #(
   parameter int p_counter_width = 16,
   parameter int p_long_cycles   = 1000,
   parameter int p_repeat_cycles = 250,
   parameter int p_double_cycles = 300
) (
   input  logic i_w_clk,
   input  logic i_w_reset,
   input  logic i_w_level,
   output logic o_w_press,
   output logic o_w_release,
   output logic o_w_single,
   output logic o_w_double,
   output logic o_w_long,
   output logic o_w_repeat,
   output logic o_w_held
);

   // Gesture states.
   //   ARMED   : only entered from reset; waits for the button to be seen
   //             released so a button held through reset is ignored.
   //   IDLE    : nothing in progress.
   //   PRESSED : first press of a gesture is being held.
   //   GAP     : first press was released short; double-click window open.
   //   SECOND  : second press of a double click is being held.
   //   LONG    : long-press threshold reached, auto-repeat running.
   typedef enum logic [2:0] {
      ST_ARMED   = 3'd0,
      ST_IDLE    = 3'd1,
      ST_PRESSED = 3'd2,
      ST_GAP     = 3'd3,
      ST_SECOND  = 3'd4,
      ST_LONG    = 3'd5
   } state_t;

   // Thresholds folded into counter width once so every compare is
   // same-width.
   localparam logic [p_counter_width-1:0] c_zero   = '0;
   localparam logic [p_counter_width-1:0] c_one    = p_counter_width'(1);
   localparam logic [p_counter_width-1:0] c_long   = p_counter_width'(p_long_cycles);
   localparam logic [p_counter_width-1:0] c_repeat = p_counter_width'(p_repeat_cycles);
   localparam logic [p_counter_width-1:0] c_double = p_counter_width'(p_double_cycles);

   state_t                     state;
   state_t                     state_next;
   logic [p_counter_width-1:0] count;
   logic [p_counter_width-1:0] count_next;
   logic [p_counter_width-1:0] count_inc;

   logic press_next;
   logic release_next;
   logic single_next;
   logic double_next;
   logic long_next;
   logic repeat_next;
   logic held_next;

   // The counter is shared by every timed state. Its meaning depends on
   // the state: high samples so far in PRESSED/SECOND, cycles since the
   // last long/repeat pulse in LONG, and cycles since the release in GAP.
   // Thresholds never exceed the counter range, so it never wraps.
   assign count_inc = count + c_one;

   // Next-state and next-output logic. Outputs are computed here from the
   // transition being taken and then registered, so each pulse appears in
   // the cycle right after the edge that sampled the deciding level.
   // Release always wins over counting: the edge that samples the button
   // low never also produces a long or repeat pulse.
   always_comb begin
      state_next   = state;
      count_next   = count;
      press_next   = 1'b0;
      release_next = 1'b0;
      single_next  = 1'b0;
      double_next  = 1'b0;
      long_next    = 1'b0;
      repeat_next  = 1'b0;

      case (state)
         ST_ARMED: begin
            count_next = c_zero;
            if (!i_w_level) begin
               state_next = ST_IDLE;
            end
         end

         ST_IDLE: begin
            count_next = c_zero;
            if (i_w_level) begin
               press_next = 1'b1;
               state_next = ST_PRESSED;
               count_next = c_one;
            end
         end

         // PRESSED and SECOND time the hold the same way; they only differ
         // in where a release goes. A short first press opens the double
         // click window, while a released second press ends the gesture
         // without any single/double decision.
         ST_PRESSED, ST_SECOND: begin
            if (!i_w_level) begin
               release_next = 1'b1;
               count_next   = c_zero;
               state_next   = (state == ST_PRESSED) ? ST_GAP : ST_IDLE;
            end else if (count_inc == c_long) begin
               long_next  = 1'b1;
               state_next = ST_LONG;
               count_next = c_zero;
            end else begin
               count_next = count_inc;
            end
         end

         // Double-click window. count_inc is the number of edges since the
         // first low sample. A high sample anywhere up to and including the
         // last window edge is a double click; if the window closes with
         // the button still up, the click is confirmed as single.
         ST_GAP: begin
            if (i_w_level) begin
               press_next  = 1'b1;
               double_next = 1'b1;
               state_next  = ST_SECOND;
               count_next  = c_one;
            end else if (count_inc == c_double) begin
               single_next = 1'b1;
               state_next  = ST_IDLE;
               count_next  = c_zero;
            end else begin
               count_next = count_inc;
            end
         end

         ST_LONG: begin
            if (!i_w_level) begin
               release_next = 1'b1;
               state_next   = ST_IDLE;
               count_next   = c_zero;
            end else if (count_inc == c_repeat) begin
               repeat_next = 1'b1;
               count_next  = c_zero;
            end else begin
               count_next = count_inc;
            end
         end

         default: begin
            state_next = ST_ARMED;
            count_next = c_zero;
         end
      endcase

      // held follows the state being entered so it rises together with
      // the press pulse and falls together with the release pulse.
      held_next = (state_next == ST_PRESSED) ||
                  (state_next == ST_SECOND)  ||
                  (state_next == ST_LONG);
   end

   // State, counter and output registers. Reset is asynchronous so an
   // aborted gesture is silenced immediately, and restarting in ARMED means
   // nothing from the aborted gesture (release, single) is ever emitted.
   always_ff @(posedge i_w_clk or negedge i_w_reset) begin
      if (!i_w_reset) begin
         state       <= ST_ARMED;
         count       <= c_zero;
         o_w_press   <= 1'b0;
         o_w_release <= 1'b0;
         o_w_single  <= 1'b0;
         o_w_double  <= 1'b0;
         o_w_long    <= 1'b0;
         o_w_repeat  <= 1'b0;
         o_w_held    <= 1'b0;
      end else begin
         state       <= state_next;
         count       <= count_next;
         o_w_press   <= press_next;
         o_w_release <= release_next;
         o_w_single  <= single_next;
         o_w_double  <= double_next;
         o_w_long    <= long_next;
         o_w_repeat  <= repeat_next;
         o_w_held    <= held_next;
      end
   end

endmodule

// File: tb/tb_button_event_decoder.sv
// ---------------------------------------------------------------------------
// tb_button_event_decoder
//
// Self-checking bench for button_event_decoder with short timing parameters.
// A table of per-cycle {level, expected outputs} records walks through the
// named gestures; a few hand-written sequences cover asynchronous reset; a
// random level stream is then checked against a timestamp-based gesture
// model. Output vectors are packed as
// {press, release, single, double, long, repeat, held}.
// ---------------------------------------------------------------------------
module tb_button_event_decoder;

   localparam int c_long   = 8;
   localparam int c_repeat = 4;
   localparam int c_double = 5;

   localparam logic [6:0] e_none   = 7'b0000000;
   localparam logic [6:0] e_press  = 7'b1000001;
   localparam logic [6:0] e_held   = 7'b0000001;
   localparam logic [6:0] e_rel    = 7'b0100000;
   localparam logic [6:0] e_single = 7'b0010000;
   localparam logic [6:0] e_double = 7'b1001001;
   localparam logic [6:0] e_long   = 7'b0000101;
   localparam logic [6:0] e_rep    = 7'b0000011;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic level = 1'b0;
   logic press, release_o, single, double_o, long_o, repeat_o, held;

   int checks = 0;
   int passes = 0;

   typedef struct {
      bit         rst;
      logic       lvl;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs[$];

   // Gesture model state: timestamps of the events that matter, in cycles.
   int m_n       = 0;
   bit m_armed   = 0;
   bit m_down    = 0;
   bit m_window  = 0;
   bit m_second  = 0;
   bit m_long    = 0;
   int m_press_t = 0;
   int m_rel_t   = 0;
   int m_long_t  = 0;

   always #5 clk = ~clk;

   button_event_decoder #(
      .p_counter_width (16),
      .p_long_cycles   (c_long),
      .p_repeat_cycles (c_repeat),
      .p_double_cycles (c_double)
   ) dut (
      .i_w_clk     (clk),
      .i_w_reset   (rst_n),
      .i_w_level   (level),
      .o_w_press   (press),
      .o_w_release (release_o),
      .o_w_single  (single),
      .o_w_double  (double_o),
      .o_w_long    (long_o),
      .o_w_repeat  (repeat_o),
      .o_w_held    (held)
   );

   function automatic logic [6:0] dutOut();
      return {press, release_o, single, double_o, long_o, repeat_o, held};
   endfunction

   function void modelReset();
      m_armed  = 0;
      m_down   = 0;
      m_window = 0;
      m_second = 0;
      m_long   = 0;
   endfunction

   // One sampled level per call; returns the outputs expected in the
   // following cycle, derived from elapsed times since press/release/long.
   function logic [6:0] modelStep(input logic lvl);
      logic [6:0] e;
      int k;
      e = e_none;
      m_n++;
      if (!m_armed) begin
         if (!lvl) m_armed = 1;
      end else if (m_down) begin
         if (!lvl) begin
            e[5]   = 1'b1;
            m_down = 0;
            if (!m_second && !m_long) begin
               m_window = 1;
               m_rel_t  = m_n;
            end
         end else if (!m_long) begin
            if (m_n - m_press_t == c_long - 1) begin
               e[2]     = 1'b1;
               m_long   = 1;
               m_long_t = m_n;
            end
         end else if ((m_n - m_long_t) % c_repeat == 0) begin
            e[1] = 1'b1;
         end
      end else if (m_window) begin
         k = m_n - m_rel_t;
         if (lvl) begin
            e[6]      = 1'b1;
            e[3]      = 1'b1;
            m_down    = 1;
            m_second  = 1;
            m_long    = 0;
            m_press_t = m_n;
            m_window  = 0;
         end else if (k == c_double) begin
            e[4]     = 1'b1;
            m_window = 0;
         end
      end else if (lvl) begin
         e[6]      = 1'b1;
         m_down    = 1;
         m_second  = 0;
         m_long    = 0;
         m_press_t = m_n;
      end
      e[0] = m_down;
      return e;
   endfunction

   function void addVec(input bit rst, input logic lvl, input logic [6:0] exp, input int n);
      vec_t v;
      v.rst = rst;
      v.lvl = lvl;
      v.exp = exp;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endfunction

   // Counts one comparison and reports it if it does not hold.
   task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s cycle %0d: got %b, want %b ({press,release,single,double,long,repeat,held})",
                    name, m_n, act, exp);
   endtask

   // Entered and left at a falling edge: drive level, let the DUT sample it,
   // then compare against the model just after the rising edge.
   task automatic applyStimulus(input logic lvl, output logic [6:0] act);
      logic [6:0] e;
      level = lvl;
      @(posedge clk);
      e = modelStep(lvl);
      #1;
      act = dutOut();
      checkOutput("model", act, e);
      @(negedge clk);
   endtask

   task automatic applyReset(input logic lvl);
      level = lvl;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("reset", dutOut(), e_none);
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset_hold", dutOut(), e_none);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [6:0] act;
      logic       lvl;
      int         run;

      // Reset with button released, then the named gestures.
      addVec(1, 1'b0, e_none, 1);
      addVec(0, 1'b0, e_none, 1);
      // single click
      addVec(0, 1'b1, e_press, 1);  addVec(0, 1'b1, e_held, 2);
      addVec(0, 1'b0, e_rel, 1);    addVec(0, 1'b0, e_none, 4);
      addVec(0, 1'b0, e_single, 1); addVec(0, 1'b0, e_none, 1);
      // double click
      addVec(0, 1'b1, e_press, 1);  addVec(0, 1'b1, e_held, 2);
      addVec(0, 1'b0, e_rel, 1);    addVec(0, 1'b0, e_none, 1);
      addVec(0, 1'b1, e_double, 1); addVec(0, 1'b1, e_held, 2);
      addVec(0, 1'b0, e_rel, 1);    addVec(0, 1'b0, e_none, 7);
      // second press on the last window edge
      addVec(0, 1'b1, e_press, 1);  addVec(0, 1'b0, e_rel, 1);
      addVec(0, 1'b0, e_none, 4);   addVec(0, 1'b1, e_double, 1);
      addVec(0, 1'b0, e_rel, 1);    addVec(0, 1'b0, e_none, 1);
      // second press one edge after the window
      addVec(0, 1'b1, e_press, 1);  addVec(0, 1'b0, e_rel, 1);
      addVec(0, 1'b0, e_none, 4);   addVec(0, 1'b0, e_single, 1);
      addVec(0, 1'b1, e_press, 1);  addVec(0, 1'b0, e_rel, 1);
      addVec(0, 1'b0, e_none, 4);   addVec(0, 1'b0, e_single, 1);
      addVec(0, 1'b0, e_none, 1);
      // long press with three repeats
      addVec(0, 1'b1, e_press, 1);  addVec(0, 1'b1, e_held, 6);
      addVec(0, 1'b1, e_long, 1);   addVec(0, 1'b1, e_held, 3);
      addVec(0, 1'b1, e_rep, 1);    addVec(0, 1'b1, e_held, 3);
      addVec(0, 1'b1, e_rep, 1);    addVec(0, 1'b1, e_held, 3);
      addVec(0, 1'b1, e_rep, 1);    addVec(0, 1'b0, e_rel, 1);
      addVec(0, 1'b0, e_none, 7);
      // second press of a double click held into long
      addVec(0, 1'b1, e_press, 1);  addVec(0, 1'b0, e_rel, 1);
      addVec(0, 1'b1, e_double, 1); addVec(0, 1'b1, e_held, 6);
      addVec(0, 1'b1, e_long, 1);   addVec(0, 1'b0, e_rel, 1);
      addVec(0, 1'b0, e_none, 7);
      // reset with the button held: silent until seen released
      addVec(1, 1'b1, e_none, 1);
      addVec(0, 1'b1, e_none, 20);  addVec(0, 1'b0, e_none, 1);
      addVec(0, 1'b1, e_press, 1);  addVec(0, 1'b0, e_rel, 1);
      addVec(0, 1'b0, e_none, 4);   addVec(0, 1'b0, e_single, 1);
      addVec(0, 1'b0, e_none, 2);

      @(negedge clk);
      $display("[TB] directed vectors: %0d", vecs.size());
      foreach (vecs[i]) begin
         if (vecs[i].rst) begin
            applyReset(vecs[i].lvl);
         end else begin
            applyStimulus(vecs[i].lvl, act);
            checkOutput("vector", act, vecs[i].exp);
         end
      end

      // Reset in the middle of a long press clears outputs without a clock.
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, act);
      checkOutput("held_before_reset", {6'b0, act[0]}, 7'b0000001);
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("async_reset", dutOut(), e_none);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, act);
      checkOutput("no_press_until_released", {act[6], 6'b0}, 7'b0);
      applyStimulus(1'b0, act);
      applyStimulus(1'b1, act);
      checkOutput("rearm_press", {act[6], 6'b0}, 7'b1000000);
      applyStimulus(1'b0, act);

      // Random level runs against the model.
      lvl = 1'b0;
      for (int r = 0; r < 250; r++) begin
         lvl = ~lvl;
         run = (($urandom % 4) == 0) ? int'($urandom_range(8, 22)) : int'($urandom_range(1, 7));
         for (int c = 0; c < run; c++) applyStimulus(lvl, act);
      end
      for (int c = 0; c < 10; c++) applyStimulus(1'b0, act);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
